sobel_window_3x3: RTL and testbench
===================================

# sobel_window_3x3

Streaming Sobel edge-detection block: accepts one 8-bit grayscale pixel per enabled clock in raster order, builds a 3x3 neighbourhood with two internal line buffers, and outputs one 8-bit gradient magnitude per fully populated window. It sits between the pixel source (camera or frame memory) and the edge-map sink/FIFO in the image pipeline.

## Interface
- IMG_WIDTH, 320, pixels per line (line-buffer depth, column wrap point); legal range 3..1023.
- DATA_W, 8, pixel width; output width is also DATA_W.

- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- frame_reset  input  1  single-cycle start-of-frame strobe; clears position state.
- datain  input  DATA_W  input pixel, raster order.
- datain_en  input  1  datain valid; a pixel is accepted on every rising edge with datain_en=1.
- dout  output  DATA_W  Sobel magnitude for the window centre.
- dout_valid  output  1  one-cycle strobe, dout holds a new result.

## Operation
- Position tracking: column counter col (0..IMG_WIDTH-1) and row counter row (saturating at 2). On accept: col increments; at IMG_WIDTH-1, col wraps to 0 and row increments (saturating).
- Line buffers: two IMG_WIDTH-deep buffers. On accept, the pixel is written to buffer A at col, buffer A's old value at col is moved to buffer B. Contents are not cleared by reset.
- Window for newest pixel P[r][c]: row 2 = P[r][c-2], P[r][c-1], P[r][c] (newest at right); row 1 = the same columns from row r-1; row 0 = row r-2. Shift registers per row advance only on accept.
- Window is valid when row>=2 and col>=2 (after the accept). Windows never straddle lines: the first two pixels of every line produce no output.
- Labelling p0..p8 row-major (p0 top-left, p4 centre, p8 bottom-right):
  - Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6)
  - Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2)
  - Intermediate sums are signed, at least DATA_W+3 bits, with no overflow.
  - dout = min(|Gx| + |Gy|, 2^DATA_W - 1), i.e. saturating.
- Each result corresponds to input pixel P[r-1][c-1]. An H-line frame yields (IMG_WIDTH-2)*(H-2) results.
- datain_en gaps (mid-line or between lines) stall all state. Results are identical to those from a gap-free stream.
- frame_reset (rst_n high):
  - Clears col, row and window-valid state; suppresses any dout_valid in the following cycle.
  - A pixel presented with frame_reset=1 is discarded.
  - Line-buffer contents are not cleared. They are not used until two new lines have been accepted.
- rst_n=0 has priority over frame_reset and datain_en. It clears col, row, window registers, pipeline valid flags, dout=0 and dout_valid=0.

## Timing
- Two-stage pipeline:
  - Edge E (accept): window registers and window-valid update.
  - Edge E+1: dout and dout_valid are registered from the window.
- Latency: dout_valid is high for exactly the cycle after edge E+1, i.e. the 2nd edge after the accepting edge.
- Back-to-back accepts give back-to-back dout_valid pulses. There is no backpressure; the sink must take every result.
- dout holds its last value while dout_valid=0.
- Reset values: dout=0, dout_valid=0. Both are observable on the edge after rst_n is sampled low.
- Reset mid-frame: the pending pipeline result is dropped and dout_valid stays 0. After release, the block behaves as at power-up: the next valid output needs 2 full lines plus 3 pixels.

## Test plan
- Flat image (all pixels 0x80), IMG_WIDTH=320, 256 lines, contiguous datain_en → exactly 318*254 = 80772 dout_valid pulses, all dout=0.
- Horizontal ramp P[r][c]=c → every dout=8 (Gx=8, Gy=0). First dout_valid occurs 2 edges after the accept of pixel (row 2, col 2), i.e. pixel index 642.
- Vertical step: rows 0..99 = 0, rows 100+ = 255 → results centred on rows 99 and 100 give dout=255 (saturated from 1020); all other rows give dout=0.
- Same 320x256 lena-style frame sent contiguous and then with random datain_en gaps (frame_reset between) → identical dout sequences and counts.
- frame_reset pulsed mid-line with datain_en=1 → that pixel is dropped, no dout_valid until 2 lines + 3 pixels later, outputs match a fresh frame.
- rst_n low for 2 cycles mid-frame → dout=0 and dout_valid=0 on the next edge, pending result suppressed, restart behaves as power-up.

Source files
------------

// File: rtl/sobel_window_3x3_if.sv
// Pixel-stream interface for the Sobel window block.
// The source drives pixels and the start-of-frame strobe; the sink receives gradient magnitudes.
interface sobel_window_3x3_if #(
    parameter int DATA_W = 8
);
    logic              frame_reset;
    logic [DATA_W-1:0] datain;
    logic              datain_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    modport master (
        output frame_reset, datain, datain_en,
        input  dout, dout_valid
    );

    modport slave (
        input  frame_reset, datain, datain_en,
        output dout, dout_valid
    );
endinterface

// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 Sobel edge detector: two line buffers build the neighbourhood,
// and a two-stage pipeline emits a saturated |Gx|+|Gy| per fully populated window.
module sobel_window_3x3 #(
    parameter int IMG_WIDTH = 320,
    parameter int DATA_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sobel_window_3x3_if.slave   bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int SW    = DATA_W + 3;

    logic [COL_W-1:0]  r_col;
    logic [1:0]        r_row;
    logic [DATA_W-1:0] r_lineA [IMG_WIDTH];
    logic [DATA_W-1:0] r_lineB [IMG_WIDTH];
    logic [DATA_W-1:0] r_win   [3][3];
    logic              r_winValid;
    logic [DATA_W-1:0] r_dout;
    logic              r_doutValid;

    logic                 w_accept;
    logic                 w_lastCol;
    logic signed [SW-1:0] w_gx;
    logic signed [SW-1:0] w_gy;
    logic [SW-1:0]        w_absX;
    logic [SW-1:0]        w_absY;
    logic [SW:0]          w_mag;
    logic [DATA_W-1:0]    w_sat;

    assign w_accept  = rst_n && bus.datain_en && !bus.frame_reset;
    assign w_lastCol = (r_col == COL_W'(IMG_WIDTH - 1));

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] v);
        return signed'({3'b000, v});
    endfunction

    // Buffer A holds the previous line, buffer B the line before it; contents survive resets.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lineA[r_col] <= bus.datain;
            r_lineB[r_col] <= r_lineA[r_col];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_winValid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[k][j] <= '0;
                end
            end
        end else if (bus.frame_reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_winValid <= 1'b0;
        end else if (bus.datain_en) begin
            for (int k = 0; k < 3; k++) begin
                r_win[k][0] <= r_win[k][1];
                r_win[k][1] <= r_win[k][2];
            end
            r_win[0][2] <= r_lineB[r_col];
            r_win[1][2] <= r_lineA[r_col];
            r_win[2][2] <= bus.datain;
            // Only windows lying wholly inside one line triplet are reported.
            r_winValid  <= (r_row == 2'd2) && (r_col >= COL_W'(2));
            if (w_lastCol) begin
                r_col <= '0;
                if (r_row != 2'd2) begin
                    r_row <= r_row + 2'd1;
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end else begin
            r_winValid <= 1'b0;
        end
    end

    always_comb begin
        w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
             - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
        w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
             - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));
        w_absX = w_gx[SW-1] ? (-w_gx) : w_gx;
        w_absY = w_gy[SW-1] ? (-w_gy) : w_gy;
        w_mag  = {1'b0, w_absX} + {1'b0, w_absY};
        w_sat  = (w_mag[SW:DATA_W] != '0) ? {DATA_W{1'b1}} : w_mag[DATA_W-1:0];
    end

    // A frame restart drops whatever result is still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_doutValid <= 1'b0;
        end else if (bus.frame_reset) begin
            r_doutValid <= 1'b0;
        end else begin
            r_doutValid <= r_winValid;
            if (r_winValid) begin
                r_dout <= w_sat;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_doutValid;
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Randomised self-checking bench for sobel_window_3x3: a frame-level Sobel model
// predicts every output value and the edge on which it must appear.
module tb_sobel_window_3x3;
    localparam int W = 12;
    localparam int H = 8;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic clk;
    logic rst_n;

    sobel_window_3x3_if #(.DATA_W(8)) bif ();

    sobel_window_3x3 #(.IMG_WIDTH(W), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared;
    int         mismatched;
    int         edgeCnt;
    int         mLine;
    int         mCol;
    int         validCnt;
    int         satCnt;
    int         firstValidEdge;
    int         frameStart;
    bit         checkOn;
    logic [7:0] expDout;
    logic [7:0] img [0:63][0:W-1];
    logic [7:0] rnd [0:H-1][0:W-1];
    exp_t       expQ [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeCnt, actual, expected);
        end
    endtask

    function automatic int sobelRef(input int p0, input int p1, input int p2,
                                    input int p3, input int p4, input int p5,
                                    input int p6, input int p7, input int p8);
        int gx, gy, m;
        gx = (p2 + 2 * p5 + p8) - (p0 + 2 * p3 + p6);
        gy = (p6 + 2 * p7 + p8) - (p0 + 2 * p1 + p2);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int windowRef(input int l, input int c);
        return sobelRef(img[l-2][c-2], img[l-2][c-1], img[l-2][c],
                        img[l-1][c-2], img[l-1][c-1], img[l-1][c],
                        img[l][c-2],   img[l][c-1],   img[l][c]);
    endfunction

    function automatic logic [7:0] pixVal(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'h80;
            1:       return 8'(c);
            2:       return (r >= 4) ? 8'd255 : 8'd0;
            default: return rnd[r][c];
        endcase
    endfunction

    // Drives one clock of inputs and advances the frame model by what that edge does.
    task automatic applyStimulus(input logic en, input logic fr, input logic [7:0] d);
        bif.datain_en   = en;
        bif.frame_reset = fr;
        bif.datain      = d;
        @(posedge clk);
        #1;
        edgeCnt++;
        if (!rst_n) begin
            mLine = 0;
            mCol  = 0;
            expQ.delete();
            expDout = 8'd0;
        end else if (fr) begin
            mLine = 0;
            mCol  = 0;
            while (expQ.size() > 0 && expQ[0].due == edgeCnt) expQ.delete(0);
        end else if (en) begin
            img[mLine][mCol] = d;
            if (mLine >= 2 && mCol >= 2) expQ.push_back('{edgeCnt + 1, windowRef(mLine, mCol)});
            mCol++;
            if (mCol == W) begin
                mCol = 0;
                if (mLine < 63) mLine++;
            end
        end
    endtask

    task automatic resetCounters();
        validCnt       = 0;
        satCnt         = 0;
        firstValidEdge = -1;
        frameStart     = edgeCnt + 1;
    endtask

    task automatic startFrame();
        applyStimulus(1'b0, 1'b1, 8'h00);
        resetCounters();
    endtask

    task automatic sendPartial(input int kind, input int nPix, input bit gaps);
        for (int i = 0; i < nPix; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) applyStimulus(1'b0, 1'b0, 8'($urandom));
            applyStimulus(1'b1, 1'b0, pixVal(kind, i / W, i % W));
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            if (bif.dout_valid === 1'b1) begin
                validCnt++;
                if (bif.dout === 8'd255) satCnt++;
                if (firstValidEdge < 0) firstValidEdge = edgeCnt;
            end
            if (expQ.size() > 0 && expQ[0].due == edgeCnt) begin
                checkOutput("result_valid", 32'(bif.dout_valid), 32'd1);
                checkOutput("result_dout", 32'(bif.dout), 32'(expQ[0].val));
                expDout = 8'(expQ[0].val);
                expQ.delete(0);
            end else begin
                checkOutput("idle_valid", 32'(bif.dout_valid), 32'd0);
                checkOutput("hold_dout", 32'(bif.dout), 32'(expDout));
            end
        end
    end

    initial begin
        compared        = 0;
        mismatched      = 0;
        edgeCnt         = 0;
        mLine           = 0;
        mCol            = 0;
        checkOn         = 1'b0;
        expDout         = 8'd0;
        rst_n           = 1'b0;
        bif.datain_en   = 1'b0;
        bif.frame_reset = 1'b0;
        bif.datain      = 8'd0;
        resetCounters();

        checkOutput("model_ramp", 32'(sobelRef(0, 1, 2, 0, 1, 2, 0, 1, 2)), 32'd8);
        checkOutput("model_step", 32'(sobelRef(0, 0, 0, 0, 0, 0, 255, 255, 255)), 32'd255);
        checkOutput("model_flat", 32'(sobelRef(128, 128, 128, 128, 128, 128, 128, 128, 128)), 32'd0);
        checkOutput("model_mixed", 32'(sobelRef(1, 2, 3, 4, 5, 6, 7, 8, 9)), 32'd32);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) rnd[r][c] = 8'($urandom);

        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("reset_dout", 32'(bif.dout), 32'd0);
        checkOutput("reset_valid", 32'(bif.dout_valid), 32'd0);
        checkOn = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);

        resetCounters();
        sendPartial(0, W * H, 1'b0);
        flush();
        checkOutput("flat_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(1, W * H, 1'b0);
        flush();
        checkOutput("ramp_first_edge", 32'(firstValidEdge), 32'(frameStart + 2 * W + 3));
        checkOutput("ramp_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(2, W * H, 1'b0);
        flush();
        checkOutput("step_sat_count", 32'(satCnt), 32'(2 * (W - 2)));
        checkOutput("step_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(3, W * H, 1'b0);
        flush();
        checkOutput("rand_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(3, W * H, 1'b1);
        flush();
        checkOutput("gap_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(3, 3 * W + 5, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hAB);
        resetCounters();
        sendPartial(3, W * H, 1'b0);
        flush();
        checkOutput("fr_first_edge", 32'(firstValidEdge), 32'(frameStart + 2 * W + 3));
        checkOutput("fr_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        startFrame();
        sendPartial(3, 4 * W + 5, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h55);
        checkOutput("midrst_dout", 32'(bif.dout), 32'd0);
        checkOutput("midrst_valid", 32'(bif.dout_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h66);
        rst_n = 1'b1;
        resetCounters();
        sendPartial(1, W * H, 1'b0);
        flush();
        checkOutput("rst_first_edge", 32'(firstValidEdge), 32'(frameStart + 2 * W + 3));
        checkOutput("rst_count", 32'(validCnt), 32'((W - 2) * (H - 2)));

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
